asi_arb: RTL and testbench
==========================

# asi_arb

Single-clock arbiter that shares the user-side memory port between the write path (`asi_w`) and the read path (`asi_r`) of the AXI slave interface. It grants one path at a time, holds the grant for a whole burst, and enforces the static priority selected by `ASI_ARB`. A starvation counter and an optional turnaround gap between owner changes bound the wait of the low-priority path. It sits in the `usr_clk` domain between the two interface halves and the user memory.

## Interface
- `ASI_ARB`, 0, priority select: 1 = read wins ties, 0 = write wins ties
- `ARB_STARVE`, 4, low-priority losses tolerated before a forced grant; 0 = pure fixed priority
- `ARB_TURN`, 1, idle cycles inserted when ownership changes between write and read; 0 = none
- `ARB_CW`, `$clog2(ARB_STARVE+2)`, starvation counter width (derived)
- `usr_clk`  in  1  clock; the block runs on this single clock
- `usr_reset_n`  in  1  asynchronous active-low reset
- `usr_wrequest`  in  1  write path has a queued burst
- `usr_we`  in  1  write beat to memory
- `usr_wlast`  in  1  last beat of write burst, qualified by `usr_we`
- `usr_wgrant`  out  1  write path owns memory port
- `usr_rrequest`  in  1  read path has a queued burst
- `usr_re`  in  1  read beat to memory
- `usr_rlast`  in  1  last beat of read burst, qualified by `usr_re`
- `usr_rgrant`  out  1  read path owns memory port
- `arb_busy`  out  1  a grant is active
- `arb_owner`  out  1  last/current owner: 0 = write, 1 = read

## Operation
- States: `ST_IDLE`, `ST_TURN`, `ST_WGNT`, `ST_RGNT`. `usr_wgrant` = (state==`ST_WGNT`) and `usr_rgrant` = (state==`ST_RGNT`), both decoded from registered state, so the two grants are never high together.
- Winner in `ST_IDLE`:
  - With one request, that side wins.
  - With both requests, the `ASI_ARB` side wins, unless `ARB_STARVE`!=0 and `starve_cc`==`ARB_STARVE`, in which case the low-priority side wins.
- `ST_IDLE` transitions:
  - No request: stay.
  - Winner equals `arb_owner`, or `ARB_TURN`==0: go to the grant state of the winner.
  - Otherwise go to `ST_TURN`, load `turn_cc`=`ARB_TURN`-1, and record the pending winner.
- `ST_TURN`: when `turn_cc`==0, go to the grant state of the pending winner; otherwise decrement. Requests are not re-evaluated here, and the pending winner is granted even if its request has dropped.
- Entering a grant state updates `arb_owner` and clears the `started` flag.
- `ST_WGNT`:
  - `usr_we` sets `started`.
  - `usr_we && usr_wlast` goes to `ST_IDLE`. This includes a single-beat burst on the first granted cycle.
  - `!started && !usr_wrequest && !usr_we` aborts to `ST_IDLE`.
  - Once `started`, a drop of the request does not end the grant.
- `ST_RGNT`: identical, using `usr_re`, `usr_rlast` and `usr_rrequest`.
- `starve_cc`, updated on every `ST_IDLE` decision with both requesters present:
  - Increment when the high-priority side wins; saturate at `ARB_STARVE`.
  - Clear to 0 whenever the low-priority side is granted.
  - Hold otherwise.
- Beats from the non-granted side are ignored and have no state effect.

## Timing
- Reset values: `usr_wgrant`=0, `usr_rgrant`=0, `arb_busy`=0, `arb_owner`=0, state=`ST_IDLE`, `starve_cc`=0, `turn_cc`=0.
- Request to grant, same owner: request sampled high in `ST_IDLE` at cycle N gives grant high at N+1.
- Owner change: grant at N+1+`ARB_TURN`.
- Release: the last-beat cycle M is still granted; grant is low at M+1 and earliest re-grant is M+2. This gives at least one grant-free cycle between bursts, so a requester cannot start a second burst on a stale grant.
- Reset asserted mid-burst: grants drop asynchronously, the counters clear, and the burst is abandoned. The requesters are reset in the same domain.

## Test plan
- Reset release with `usr_wrequest`=`usr_rrequest`=1, `ASI_ARB`=0 → `usr_wgrant`=1 at cycle 1, `usr_rgrant`=0. After a 4-beat write (`usr_wlast` on beat 4 at cycle M), `usr_wgrant`=0 at M+1, the turn cycle is at M+2, and `usr_rgrant`=1 at M+3.
- `ASI_ARB`=1, both requesting continuously, 1-beat bursts → the read side is granted first, every burst is separated by ≥1 idle cycle, and both grants are never 1 in the same cycle.
- Starvation with `ARB_STARVE`=4, `ASI_ARB`=0, write always requesting, read requesting → 4 write bursts, then a forced read grant, and `starve_cc` returns to 0.
- Abort: grant write with `usr_wrequest` dropped and no `usr_we` → `ST_IDLE` next cycle and `usr_wgrant`=0. With `started`=1, a request drop holds the grant until `usr_wlast`.
- Single-beat write with `usr_we`&`usr_wlast` on the first granted cycle → grant held exactly 1 cycle. With `ARB_TURN`=0 and `ARB_TURN`=3, an owner switch to read gives a gap of 1 and 4 grant-free cycles respectively.
- Assert `usr_reset_n`=0 mid 8-beat read → `usr_rgrant`=0 immediately, all outputs reset, and normal arbitration resumes after release.

Source files
------------

// File: rtl/asi_arb.sv
// Memory-port arbiter between the AXI slave write and read paths: burst-long grants,
// static priority with starvation escape, and an optional turnaround gap on owner change.
module asi_arb #(
  parameter int ASI_ARB    = 0,
  parameter int ARB_STARVE = 4,
  parameter int ARB_TURN   = 1,
  parameter int ARB_CW     = $clog2(ARB_STARVE + 2)
) (
  input  logic usr_clk,
  input  logic usr_reset_n,
  input  logic usr_wrequest,
  input  logic usr_we,
  input  logic usr_wlast,
  output logic usr_wgrant,
  input  logic usr_rrequest,
  input  logic usr_re,
  input  logic usr_rlast,
  output logic usr_rgrant,
  output logic arb_busy,
  output logic arb_owner
);

  localparam int TW = (ARB_TURN > 1) ? $clog2(ARB_TURN) : 1;
  localparam logic HP_RD = (ASI_ARB != 0);
  localparam logic [ARB_CW-1:0] STARVE_MAX = ARB_CW'(ARB_STARVE);
  localparam logic [TW-1:0] TURN_LOAD = (ARB_TURN > 0) ? TW'(ARB_TURN - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_WGNT,
    ST_RGNT
  } state_e;

  state_e            state_q;
  logic [ARB_CW-1:0] starve_cc_q;
  logic [TW-1:0]     turn_cc_q;
  logic              owner_q;
  logic              pend_q;
  logic              started_q;

  logic any_req;
  logic both_req;
  logic force_low;
  logic win_rd;

  // Starvation escape flips the static winner only when both sides compete.
  always_comb begin
    any_req   = usr_wrequest | usr_rrequest;
    both_req  = usr_wrequest & usr_rrequest;
    force_low = (ARB_STARVE != 0) && (starve_cc_q == STARVE_MAX);
    win_rd    = both_req ? (HP_RD ^ force_low) : usr_rrequest;
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q     <= ST_IDLE;
      starve_cc_q <= '0;
      turn_cc_q   <= '0;
      owner_q     <= 1'b0;
      pend_q      <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            if (win_rd != HP_RD) begin
              starve_cc_q <= '0;
            end else if (both_req && (starve_cc_q != STARVE_MAX)) begin
              starve_cc_q <= starve_cc_q + 1'b1;
            end
            if ((win_rd == owner_q) || (ARB_TURN == 0)) begin
              state_q   <= win_rd ? ST_RGNT : ST_WGNT;
              owner_q   <= win_rd;
              started_q <= 1'b0;
            end else begin
              state_q   <= ST_TURN;
              turn_cc_q <= TURN_LOAD;
              pend_q    <= win_rd;
            end
          end
        end
        // The pending winner is committed; requests are not looked at again here.
        ST_TURN: begin
          if (turn_cc_q == '0) begin
            state_q   <= pend_q ? ST_RGNT : ST_WGNT;
            owner_q   <= pend_q;
            started_q <= 1'b0;
          end else begin
            turn_cc_q <= turn_cc_q - 1'b1;
          end
        end
        ST_WGNT: begin
          if (usr_we && usr_wlast) begin
            state_q <= ST_IDLE;
          end else if (!started_q && !usr_wrequest && !usr_we) begin
            state_q <= ST_IDLE;
          end else if (usr_we) begin
            started_q <= 1'b1;
          end
        end
        ST_RGNT: begin
          if (usr_re && usr_rlast) begin
            state_q <= ST_IDLE;
          end else if (!started_q && !usr_rrequest && !usr_re) begin
            state_q <= ST_IDLE;
          end else if (usr_re) begin
            started_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign usr_wgrant = (state_q == ST_WGNT);
  assign usr_rgrant = (state_q == ST_RGNT);
  assign arb_busy   = usr_wgrant | usr_rgrant;
  assign arb_owner  = owner_q;

endmodule

// File: tb/tb_asi_arb.sv
// Scoreboard bench for asi_arb: burst drivers per path, expected grants queued per scenario
// and matched against observed grant windows (side, start cycle, length).
module tb_asi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] wreq = '0, we = '0, wlast = '0;
  logic [3:0] rreq = '0, re = '0, rlast = '0;
  wire  [3:0] wgnt, rgnt, busy, owner;

  initial forever #5 clk = ~clk;

  asi_arb #(.ASI_ARB(0), .ARB_STARVE(4), .ARB_TURN(1)) dut0 (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq[0]), .usr_we(we[0]), .usr_wlast(wlast[0]), .usr_wgrant(wgnt[0]),
    .usr_rrequest(rreq[0]), .usr_re(re[0]), .usr_rlast(rlast[0]), .usr_rgrant(rgnt[0]),
    .arb_busy(busy[0]), .arb_owner(owner[0]));

  asi_arb #(.ASI_ARB(1), .ARB_STARVE(4), .ARB_TURN(1)) dut1 (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq[1]), .usr_we(we[1]), .usr_wlast(wlast[1]), .usr_wgrant(wgnt[1]),
    .usr_rrequest(rreq[1]), .usr_re(re[1]), .usr_rlast(rlast[1]), .usr_rgrant(rgnt[1]),
    .arb_busy(busy[1]), .arb_owner(owner[1]));

  asi_arb #(.ASI_ARB(0), .ARB_STARVE(4), .ARB_TURN(0)) dut2 (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq[2]), .usr_we(we[2]), .usr_wlast(wlast[2]), .usr_wgrant(wgnt[2]),
    .usr_rrequest(rreq[2]), .usr_re(re[2]), .usr_rlast(rlast[2]), .usr_rgrant(rgnt[2]),
    .arb_busy(busy[2]), .arb_owner(owner[2]));

  asi_arb #(.ASI_ARB(0), .ARB_STARVE(4), .ARB_TURN(3)) dut3 (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq[3]), .usr_we(we[3]), .usr_wlast(wlast[3]), .usr_wgrant(wgnt[3]),
    .usr_rrequest(rreq[3]), .usr_re(re[3]), .usr_rlast(rlast[3]), .usr_rgrant(rgnt[3]),
    .arb_busy(busy[3]), .arb_owner(owner[3]));

  typedef struct {
    bit side;
    int start;
    int dur;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   sel = 0;
  bit   drv_en = 1'b0;
  bit   mon_en = 1'b0;
  int   wq[$];
  int   rq[$];
  int   bc[2];
  bit   hole[2], drop[2], stray[2];
  exp_t sb[$];
  bit   pw, pr;
  int   dur_cnt, dur_exp;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, dut%0d)", tag, got, exp, cyc, sel);
    end
  endtask

  task automatic exp_grant(input bit side, input int start, input int dur);
    exp_t e;
    e.side = side;
    e.start = start;
    e.dur = dur;
    sb.push_back(e);
  endtask

  // One path of the requester: beats while granted, a length-0 entry means request then abort.
  task automatic side_step(input int s, input bit g, output bit beat, output bit last, output bit req);
    int qsz, head;
    qsz  = (s != 0) ? rq.size() : wq.size();
    head = (qsz > 0) ? ((s != 0) ? rq[0] : wq[0]) : 0;
    beat = 1'b0;
    last = 1'b0;
    if (g && qsz > 0) begin
      if (head == 0) begin
        if (s != 0) void'(rq.pop_front()); else void'(wq.pop_front());
      end else if (hole[s] && bc[s] == 1) begin
        hole[s] = 1'b0;
      end else begin
        bc[s]++;
        beat = 1'b1;
        if (bc[s] == head) begin
          last = 1'b1;
          bc[s] = 0;
          if (s != 0) void'(rq.pop_front()); else void'(wq.pop_front());
        end
      end
    end else if (!g && stray[s]) begin
      beat = 1'b1;
      last = 1'b1;
    end
    qsz = (s != 0) ? rq.size() : wq.size();
    req = (qsz > 0) && !(drop[s] && bc[s] > 0);
  endtask

  task automatic drive_step();
    bit b, l, r;
    side_step(0, wgnt[sel], b, l, r);
    we[sel] = b; wlast[sel] = l; wreq[sel] = r;
    side_step(1, rgnt[sel], b, l, r);
    re[sel] = b; rlast[sel] = l; rreq[sel] = r;
  endtask

  task automatic mon_step();
    bit w, r, g;
    exp_t e;
    w = wgnt[sel];
    r = rgnt[sel];
    g = w | r;
    chk("excl", int'(w & r), 0);
    if (g && !(pw | pr)) begin
      if (sb.size() == 0) begin
        chk("sb_depth", sb.size(), 1);
        dur_exp = 0;
      end else begin
        e = sb.pop_front();
        chk("side", int'(r), int'(e.side));
        chk("start", cyc, e.start);
        chk("owner", int'(owner[sel]), int'(e.side));
        chk("busy", int'(busy[sel]), 1);
        dur_exp = e.dur;
      end
      dur_cnt = 0;
    end
    if (g) dur_cnt++;
    if (!g && (pw | pr) && dur_exp > 0) chk("dur", dur_cnt, dur_exp);
    pw = w;
    pr = r;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (drv_en) drive_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) mon_step();
  end

  task automatic start_scn(input int s);
    mon_en = 1'b0;
    drv_en = 1'b0;
    rst_n  = 1'b0;
    wreq = '0; we = '0; wlast = '0;
    rreq = '0; re = '0; rlast = '0;
    wq.delete();
    rq.delete();
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      bc[i] = 0; hole[i] = 1'b0; drop[i] = 1'b0; stray[i] = 1'b0;
    end
    pw = 1'b0; pr = 1'b0; dur_cnt = 0; dur_exp = 0;
    sel = s;
    repeat (2) @(negedge clk);
    chk("rst_wgnt", int'(wgnt[s]), 0);
    chk("rst_rgnt", int'(rgnt[s]), 0);
    chk("rst_busy", int'(busy[s]), 0);
    chk("rst_owner", int'(owner[s]), 0);
  endtask

  task automatic go();
    wreq[sel] = (wq.size() > 0);
    rreq[sel] = (rq.size() > 0);
    @(negedge clk);
    #2;
    cyc    = 0;
    rst_n  = 1'b1;
    drv_en = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic finish_scn(input int n);
    repeat (n) @(posedge clk);
    #3;
    chk("sb_left", sb.size(), 0);
  endtask

  initial begin
    #1;
    // Both request out of reset, write wins, then read after one turnaround cycle.
    start_scn(0);
    wq = {4}; rq = {2};
    stray[1] = 1'b1;
    exp_grant(0, 1, 4);
    exp_grant(1, 7, 2);
    go();
    finish_scn(14);
    chk("owner_end", int'(owner[0]), 1);

    // Read has priority, single-beat bursts from both sides.
    start_scn(1);
    wq = {1, 1, 1}; rq = {1, 1, 1};
    exp_grant(1, 2, 1); exp_grant(1, 4, 1); exp_grant(1, 6, 1);
    exp_grant(0, 9, 1); exp_grant(0, 11, 1); exp_grant(0, 13, 1);
    go();
    finish_scn(20);

    // Starvation escape after four write wins.
    start_scn(0);
    wq = {1, 1, 1, 1, 1, 1}; rq = {1};
    exp_grant(0, 1, 1); exp_grant(0, 3, 1); exp_grant(0, 5, 1); exp_grant(0, 7, 1);
    exp_grant(1, 10, 1); exp_grant(0, 13, 1); exp_grant(0, 15, 1);
    go();
    repeat (8) @(posedge clk);
    #3;
    chk("starve_sat", int'(dut0.starve_cc_q), 4);
    @(posedge clk);
    #3;
    chk("starve_clr", int'(dut0.starve_cc_q), 0);
    finish_scn(10);

    // Abort: granted write with request dropped and no beat.
    start_scn(0);
    wq = {0};
    exp_grant(0, 1, 1);
    go();
    finish_scn(6);

    // Started burst survives a request drop and a beat-free cycle.
    start_scn(0);
    wq = {3};
    drop[0] = 1'b1;
    hole[0] = 1'b1;
    exp_grant(0, 1, 4);
    go();
    finish_scn(8);

    // Owner switch without turnaround.
    start_scn(2);
    wq = {1}; rq = {1};
    exp_grant(0, 1, 1);
    exp_grant(1, 3, 1);
    go();
    finish_scn(8);

    // Owner switch with three turnaround cycles.
    start_scn(3);
    wq = {1}; rq = {1};
    exp_grant(0, 1, 1);
    exp_grant(1, 6, 1);
    go();
    finish_scn(10);

    // Reset in the middle of an 8-beat read.
    start_scn(0);
    rq = {8};
    exp_grant(1, 2, 0);
    go();
    repeat (5) @(posedge clk);
    #3;
    chk("rg_pre", int'(rgnt[0]), 1);
    chk("owner_pre", int'(owner[0]), 1);
    mon_en = 1'b0;
    drv_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rg_async", int'(rgnt[0]), 0);
    chk("busy_async", int'(busy[0]), 0);
    chk("owner_async", int'(owner[0]), 0);
    chk("starve_async", int'(dut0.starve_cc_q), 0);
    chk("turn_async", int'(dut0.turn_cc_q), 0);
    chk("sb_mid", sb.size(), 0);

    start_scn(0);
    wq = {2};
    exp_grant(0, 1, 2);
    go();
    finish_scn(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
